// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// Patterns are passed in 8 bits wide, MSB-aligned to bit pat_w-1 (first bit received).
package seq_det_pkg;

  localparam int          MAX_PAT_W   = 8;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bit 'pos' of the pattern vector (pos counted from the LSB).
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int pos);
    logic [MAX_PAT_W-1:0] t;
    t = pat >> pos;
    return t[0];
  endfunction

  // Longest proper prefix of the pattern that is a suffix of
  // (first k pattern bits, followed by b). Proper means shorter than pat_w.
  function automatic int longest_border(input logic [MAX_PAT_W-1:0] pat, input int pat_w,
                                        input int k, input logic b);
    int   best;
    int   j;
    logic ok;
    logic sb;
    best = 0;
    for (int l = 1; (l <= k + 1) && (l < pat_w); l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        j  = k + 1 - l + i;
        sb = (j == k) ? b : pat_bit(pat, pat_w - 1 - j);
        if (sb != pat_bit(pat, pat_w - 1 - i)) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // Target after the expected bit arrives in state k; for k == pat_w-1 this is the overlap border.
  function automatic int next_on_match(input logic [MAX_PAT_W-1:0] pat, input int pat_w,
                                       input int k);
    return longest_border(pat, pat_w, k, pat_bit(pat, pat_w - 1 - k));
  endfunction

  function automatic int next_on_miss(input logic [MAX_PAT_W-1:0] pat, input int pat_w,
                                      input int k, input logic b);
    return longest_border(pat, pat_w, k, b);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;
  logic         sat_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == MAX - 1'b1) sat_q <= 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/seq_pattern_detect.sv
// KMP-style serial pattern detector: registered hit pulse plus saturating match count.
module seq_pattern_detect
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    bit_i,
  input  logic                    bit_vld_i,
  input  logic                    clr_i,
  output logic                    hit_o,
  output logic [CNT_W-1:0]        hit_cnt_o,
  output logic                    sat_o,
  output logic [clog2(PAT_W)-1:0] state_o
);

  localparam int                   SW      = clog2(PAT_W);
  localparam int                   NS      = 1 << SW;
  localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);
  localparam logic [SW-1:0]        LAST    = SW'(PAT_W - 1);

  // Per-state expected bit and transition targets, all fixed at elaboration.
  logic [NS-1:0] exp_bit;
  logic [SW-1:0] tgt_match [NS];
  logic [SW-1:0] tgt_miss  [NS];

  for (genvar k = 0; k < NS; k++) begin : g_tbl
    if (k < PAT_W) begin : g_live
      localparam logic EB = pat_bit(PAT_EXT, PAT_W - 1 - k);
      localparam int   NM = next_on_match(PAT_EXT, PAT_W, k);
      localparam int   NX = next_on_miss(PAT_EXT, PAT_W, k, ~EB);
      assign exp_bit[k]   = EB;
      assign tgt_match[k] = SW'(NM);
      assign tgt_miss[k]  = SW'(NX);
    end else begin : g_dead
      assign exp_bit[k]   = 1'b0;
      assign tgt_match[k] = '0;
      assign tgt_miss[k]  = '0;
    end
  end

  logic [SW-1:0] state_q;
  logic          hit_q;
  logic [SW-1:0] state_nxt;
  logic          legal;
  logic          full;

  always_comb begin
    legal     = (int'(state_q) < PAT_W);
    full      = 1'b0;
    state_nxt = '0;
    if (legal) begin
      if (bit_i == exp_bit[state_q]) begin
        if (state_q == LAST) begin
          full      = bit_vld_i;
          state_nxt = (OVERLAP != 0) ? tgt_match[state_q] : '0;
        end else begin
          state_nxt = state_q + 1'b1;
        end
      end else begin
        state_nxt = tgt_miss[state_q];
      end
    end
  end

  // Clear wins over a bit sampled in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= '0;
      hit_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= full;
      if (bit_vld_i) state_q <= state_nxt;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (clr_i),
    .inc_i  (full),
    .cnt_o  (hit_cnt_o),
    .sat_o  (sat_o)
  );

  assign hit_o   = hit_q;
  assign state_o = state_q;

endmodule

// File: doc/seq_pattern_detect.md
Name: seq_pattern_detect

Overview:
Serial bit-pattern detector that sits directly downstream of the state-machine pattern generator stage. It consumes the 1-bit stream that the generator drives out on its output and matches a parameterised PATTERN, with optional overlap. It raises a registered one-cycle hit pulse on each match and keeps a saturating count of matches. Intended for self-checking the generator and for bring-up on the board.

Parameters:
PAT_W, 4, pattern length in bits (2..8).
PATTERN, 4'b1011, target sequence. MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = state restarts at 0 after a hit.
CNT_W, 8, width of the match counter.

Ports:
clk_i  input  1  system clock, rising edge.
rst_n_i  input  1  asynchronous, active-low reset.
bit_i  input  1  serial data bit; connects to the generator output.
bit_vld_i  input  1  bit_i is sampled only when this is 1. Tie high for free-running sources.
clr_i  input  1  synchronous clear of the FSM state, counter and sat flag.
hit_o  output  1  one-cycle pulse, registered, on pattern completion.
hit_cnt_o  output  CNT_W  number of hits since reset or clear; saturating.
sat_o  output  1  sticky flag: counter has reached all-ones.
state_o  output  clog2(PAT_W)  current matched-prefix length, for debug.

Behaviour:
- Reset (rst_n_i=0, asynchronous): state=0, hit_o=0, hit_cnt_o=0, sat_o=0.
- FSM: state S_k, k=0..PAT_W-1, where k = number of PATTERN bits matched so far (prefix length).
- On bit_vld_i=1, the expected bit is e = PATTERN[PAT_W-1-k].
  - bit_i==e and k<PAT_W-1: go to S_(k+1).
  - bit_i==e and k==PAT_W-1: full match.
    - hit_o=1 on the next cycle; hit_cnt_o increments.
    - Next state is S_f, where f = longest proper prefix of PATTERN that is also a suffix (OVERLAP=1), or S_0 (OVERLAP=0).
  - bit_i!=e: next state is the longest prefix of PATTERN that is a suffix of the received bits (KMP fallback).
- Fallback and overlap targets are computed by elaboration-time constant functions from PATTERN. No runtime tables.
- bit_vld_i=0: state holds, hit_o=0, counter holds.
- Latency: hit_o asserts exactly 1 clock after the rising edge that samples the final pattern bit. It never stays high more than 1 cycle per match.
- Back-to-back hits are possible when OVERLAP=1 and the overlap f == PAT_W-1 (e.g. PATTERN 1111). In that case hit_o stays high on consecutive cycles, one cycle per match.
- Counter: +1 per hit. At all-ones it holds and sat_o=1 (sticky until clr_i or reset). No wrap.
- clr_i=1: priority over bit_vld_i.
  - Next cycle: state=0, hit_o=0, hit_cnt_o=0, sat_o=0.
  - A bit sampled in the same cycle is discarded.
- Reset mid-pattern: the partial match is lost. Matching restarts from S_0 after release.
- state_o is the registered state, directly.
- Illegal state encodings (PAT_W not a power of 2) recover to S_0 on the next valid bit.

Decomposition:
- Shared package seq_det_pkg:
  - clog2 function.
  - Constant functions next_on_match(k) and next_on_miss(k, bit), parameterised by PATTERN and PAT_W.
  - Default PATTERN constant.
- Sub-module sat_counter (params W; ports clk_i, rst_n_i, clr_i, inc_i, cnt_o, sat_o), reusable elsewhere.
- The FSM and hit register stay in seq_pattern_detect.

Test Plan:
1. PATTERN=1011, OVERLAP=1, bit_vld_i=1, stream 1,0,1,1,0,1,1 -> hit_o high the cycle after bits 4 and 7; hit_cnt_o=2.
2. Same stream, OVERLAP=0 -> single hit after bit 4; hit_cnt_o=1; state_o=0 the cycle after the hit.
3. Chained behind the generator (alternating 0,1,0,1,...), PATTERN=0101, OVERLAP=1 -> first hit 1 cycle after the 4th bit, then a hit every 2 cycles; hit_cnt_o = 1, 2, 3, ...
4. PATTERN=1011, stream 1,0,1,1 with bit_vld_i=0 for 3 cycles between each bit -> exactly one hit, 1 cycle after the last valid bit; state_o holds during gaps.
5. CNT_W=2, generate 5 matches -> hit_cnt_o = 1, 2, 3, 3, 3; sat_o=1 from the 3rd hit. Then pulse clr_i -> hit_cnt_o=0, sat_o=0, state_o=0.
6. Feed 1,0,1, assert rst_n_i=0 mid-cycle (async), release, then feed 1 -> no hit; all outputs 0 during reset. Then feed 0,1,1 -> hit.
